// File: rtl/corevx_tlb_pkg.sv
// corevx_tlb_pkg: access-tag bit layout, disabled-mode tag and TLB entry format.
// Entry field widths come from the package, so the TLB parameters default to these values.
package corevx_tlb_pkg;
    localparam int AT_V = 0, AT_R = 1, AT_W = 2, AT_X = 3, AT_U = 4, AT_G = 5, AT_A = 6, AT_D = 7;
    localparam logic [7:0] TAG_DISABLED = 8'hDF;
    localparam int TLB_ENTRIES_W = 4;
    localparam int TLB_ASID_W = 9;
    localparam int TLB_VPN_W = 20;
    localparam int TLB_PPN_W = 22;
    localparam int TLB_TAG_W = TLB_VPN_W - TLB_ENTRIES_W;
    typedef struct packed {
        logic [TLB_TAG_W-1:0] tag;
        logic [TLB_ASID_W-1:0] asid;
        logic [7:1] acc;
        logic [TLB_PPN_W-1:0] ppn;
    } entry_t;
endpackage

// File: rtl/corevx_tlb_assoc_if.sv
// corevx_tlb_assoc_if: lookup, fill and flush bus between the MMU/front end and the TLB.
interface corevx_tlb_assoc_if #(
    parameter int WAYS_W = 1,
    parameter int ASID_W = 9,
    parameter int VPN_W = 20,
    parameter int PPN_W = 22
);
    logic enable, resolve, write, invalidate_all, invalidate_va;
    logic [ASID_W-1:0] asid, asid_w;
    logic [VPN_W-1:0] vpn, vpn_w;
    logic [7:0] accesstag_w, accesstag_r;
    logic [PPN_W-1:0] ppn_w, ppn_r;
    logic done, miss;
    logic [WAYS_W-1:0] hit_way;
    modport master (
        output enable, asid, vpn, resolve, write, invalidate_all, invalidate_va,
        output vpn_w, asid_w, accesstag_w, ppn_w,
        input done, miss, hit_way, accesstag_r, ppn_r
    );
    modport slave (
        input enable, asid, vpn, resolve, write, invalidate_all, invalidate_va,
        input vpn_w, asid_w, accesstag_w, ppn_w,
        output done, miss, hit_way, accesstag_r, ppn_r
    );
endinterface

// File: rtl/corevx_tlb_bank.sv
// corevx_tlb_bank: one TLB way - valid bits, entry storage, lookup hit and write-side match.
module corevx_tlb_bank
    import corevx_tlb_pkg::*;
#(
    parameter int ENTRIES_W = TLB_ENTRIES_W
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic we,
    input  logic kill,
    input  logic wvalid,
    input  logic [ENTRIES_W-1:0] widx,
    input  logic [ENTRIES_W-1:0] ridx,
    input  entry_t wdata,
    input  logic [TLB_TAG_W-1:0] rtag,
    input  logic [TLB_ASID_W-1:0] rasid,
    output logic hit,
    output logic wmatch,
    output logic wvld,
    output entry_t rdata
);
    localparam int SETS = 2**ENTRIES_W;
    logic [SETS-1:0] valid;
    entry_t mem [SETS];
    entry_t went;
    always_ff @(posedge clk)
        if (rst || flush) valid <= '0;
        else if (we) valid[widx] <= wvalid;
        else if (kill) valid[widx] <= 1'b0;
    always_ff @(posedge clk)
        if (we) mem[widx] <= wdata;
    assign rdata = mem[ridx];
    assign went = mem[widx];
    assign hit = valid[ridx] && rdata.tag == rtag && (rdata.acc[AT_G] || rdata.asid == rasid);
    // Global entries match any ASID on the fill/flush side as well as on lookup.
    assign wmatch = valid[widx] && went.tag == wdata.tag && (went.acc[AT_G] || went.asid == wdata.asid);
    assign wvld = valid[widx];
endmodule

// File: rtl/corevx_tlb_assoc.sv
// corevx_tlb_assoc: N-way set-associative TLB with ASID tags, write-merge and per-set round-robin refill.
module corevx_tlb_assoc
    import corevx_tlb_pkg::*;
#(
    parameter int ENTRIES_W = TLB_ENTRIES_W,
    parameter int WAYS_W = 1,
    parameter int ASID_W = TLB_ASID_W,
    parameter int VPN_W = TLB_VPN_W,
    parameter int PPN_W = TLB_PPN_W
) (
    input logic clk,
    input logic rst,
    corevx_tlb_assoc_if.slave bus
);
    localparam int SETS = 2**ENTRIES_W;
    localparam int WAYS = 2**WAYS_W;
    logic do_wr, do_all, do_va;
    logic pend, en_q;
    logic [VPN_W-1:0] vpn_q;
    logic [ASID_W-1:0] asid_q;
    logic [WAYS_W-1:0] ptr [SETS];
    logic [ENTRIES_W-1:0] widx;
    logic [WAYS-1:0] hit, wmatch, wvld;
    entry_t rd [WAYS];
    entry_t wdata;
    logic [WAYS_W-1:0] msel, isel, wsel, hsel;
    logic mfound, ifound, hfound;

    assign do_wr = bus.write && !bus.resolve;
    assign do_all = bus.invalidate_all && !bus.resolve && !bus.write;
    assign do_va = bus.invalidate_va && !bus.resolve && !bus.write && !bus.invalidate_all;
    assign widx = bus.vpn_w[ENTRIES_W-1:0];
    assign wdata = '{tag: bus.vpn_w[VPN_W-1:ENTRIES_W], asid: bus.asid_w, acc: bus.accesstag_w[7:1], ppn: bus.ppn_w};

    always_ff @(posedge clk)
        if (rst) begin
            pend <= 1'b0;
            en_q <= 1'b0;
        end else begin
            pend <= bus.resolve;
            if (bus.resolve) begin
                en_q <= bus.enable;
                vpn_q <= bus.vpn;
                asid_q <= bus.asid;
            end
        end

    // The victim pointer only advances when a fill has to evict a live entry.
    always_ff @(posedge clk)
        if (rst || do_all) for (int s = 0; s < SETS; s++) ptr[s] <= '0;
        else if (do_wr && !mfound && !ifound) ptr[widx] <= ptr[widx] + 1'b1;

    for (genvar k = 0; k < WAYS; k++) begin : g_way
        corevx_tlb_bank #(.ENTRIES_W(ENTRIES_W)) u_bank (
            .clk(clk),
            .rst(rst),
            .flush(do_all),
            .we(do_wr && wsel == WAYS_W'(k)),
            .kill(do_va && wmatch[k]),
            .wvalid(bus.accesstag_w[AT_V]),
            .widx(widx),
            .ridx(vpn_q[ENTRIES_W-1:0]),
            .wdata(wdata),
            .rtag(vpn_q[VPN_W-1:ENTRIES_W]),
            .rasid(asid_q),
            .hit(hit[k]),
            .wmatch(wmatch[k]),
            .wvld(wvld[k]),
            .rdata(rd[k])
        );
    end

    // Scanning downward leaves the lowest matching way selected.
    always_comb begin
        msel = '0;
        isel = '0;
        hsel = '0;
        mfound = 1'b0;
        ifound = 1'b0;
        hfound = 1'b0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (wmatch[k]) begin msel = WAYS_W'(k); mfound = 1'b1; end
            if (!wvld[k]) begin isel = WAYS_W'(k); ifound = 1'b1; end
            if (hit[k]) begin hsel = WAYS_W'(k); hfound = 1'b1; end
        end
    end
    assign wsel = mfound ? msel : ifound ? isel : ptr[widx];

    always_comb begin
        bus.done = pend;
        bus.miss = pend && en_q && !hfound;
        bus.hit_way = (pend && en_q && hfound) ? hsel : '0;
        bus.accesstag_r = !pend ? '0 : !en_q ? TAG_DISABLED : hfound ? {rd[hsel].acc, 1'b1} : '0;
        bus.ppn_r = !pend ? '0 : !en_q ? PPN_W'(vpn_q) : hfound ? rd[hsel].ppn : '0;
    end
endmodule
